// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared configuration helpers for the pipelined ripple-carry adder
//
// Contents:
//   RCA_MAX_STAGES  : upper bound on pipeline depth
//   rca_stage_vld_t : per-stage valid shift vector (only the low STAGES bits are meaningful)
//   rca_cfg_legal   : WIDTH/STAGES legality check
//   rca_chunk_width : bits handled by each pipeline stage

package rca_pkg;

    localparam int RCA_MAX_STAGES = 64;

    typedef logic [RCA_MAX_STAGES-1:0] rca_stage_vld_t;

    function automatic bit rca_cfg_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               (stages <= RCA_MAX_STAGES) && ((width % stages) == 0);
    endfunction

    // Guarded so an illegal STAGES=0 still elaborates far enough to hit the legality error.
    function automatic int rca_chunk_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Ports:
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_c      : carry out

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - CHUNK-bit combinational ripple built from full_adder cells
//
// Ports:
//   i_a, i_b : CHUNK-bit operand slices (i_b already conditioned for subtract)
//   i_cin    : carry into bit 0
//   o_s      : CHUNK-bit sum slice
//   o_cout   : carry out of the top bit
//   o_c_msb  : carry into the top bit (signed overflow source)

module rca_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_carry_adder.sv
// rtl/pipelined_ripple_carry_adder.sv - WIDTH-bit add/subtract split into STAGES registered ripple chunks
//
// Optional feature macro: PIPELINED_RCA_OVF_EN (adds the registered signed-overflow output Ovf).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake
//   A, B, Cin, Sub      : operands; Sub=0 -> A+B+Cin, Sub=1 -> A-B-Cin
//   out_valid/out_ready : result handshake
//   S, Cout             : result and raw carry-out of the MSB chunk (1 = no borrow in sub mode)
//   Ovf                 : signed overflow (macro builds only)

module pipelined_ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPELINED_RCA_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CHUNK = rca_chunk_width(WIDTH, STAGES);

    if (!rca_cfg_legal(WIDTH, STAGES)) begin : gen_bad_cfg
        $error("pipelined_ripple_carry_adder: illegal WIDTH/STAGES combination");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Stage k register holds: operands passed on to later stages, the partial
    // result with chunks 0..k filled in, and the carry out of chunk k.
    rca_stage_vld_t   r_vld;
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic [STAGES-1:0] r_c;

    logic [WIDTH-1:0]  w_a_src [STAGES];
    logic [WIDTH-1:0]  w_b_src [STAGES];
    logic [WIDTH-1:0]  w_s_src [STAGES];
    logic [WIDTH-1:0]  w_s_nxt [STAGES];
    logic [STAGES-1:0] w_c_src;
    logic [STAGES-1:0] w_c_out;
    logic [STAGES-1:0] w_c_msb;

    // The whole pipe moves as one: it advances whenever the output slot is free
    // or being drained this cycle, otherwise every stage holds.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    // Subtract as A + ~B + ~Cin so Cin acts as a borrow-in.
    assign w_b_eff = Sub ? ~B : B;
    assign w_c0    = Sub ? ~Cin : Cin;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic [CHUNK-1:0] w_s_chunk;
        logic [WIDTH-1:0] w_s_merge;

        if (k == 0) begin : gen_first
            assign w_a_src[k] = A;
            assign w_b_src[k] = w_b_eff;
            assign w_c_src[k] = w_c0;
            assign w_s_src[k] = '0;
        end else begin : gen_next
            assign w_a_src[k] = r_a[k-1];
            assign w_b_src[k] = r_b[k-1];
            assign w_c_src[k] = r_c[k-1];
            assign w_s_src[k] = r_s[k-1];
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a     (w_a_src[k][k*CHUNK +: CHUNK]),
            .i_b     (w_b_src[k][k*CHUNK +: CHUNK]),
            .i_cin   (w_c_src[k]),
            .o_s     (w_s_chunk),
            .o_cout  (w_c_out[k]),
            .o_c_msb (w_c_msb[k])
        );

        always_comb begin
            w_s_merge                     = w_s_src[k];
            w_s_merge[k*CHUNK +: CHUNK]   = w_s_chunk;
        end

        assign w_s_nxt[k] = w_s_merge;
    end

    // Operand bits already consumed, and the result bits not yet computed, ride
    // along unused in the stage registers and drop out in synthesis; carrying
    // full words keeps the skew/de-skew alignment trivially correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld <= {r_vld[RCA_MAX_STAGES-2:0], in_valid};
            r_c   <= w_c_out;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_src[k];
                r_b[k] <= w_b_src[k];
                r_s[k] <= w_s_nxt[k];
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign S         = r_s[STAGES-1];
    assign Cout      = r_c[STAGES-1];

`ifdef PIPELINED_RCA_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_c_msb[STAGES-1] ^ w_c_out[STAGES-1];
        end
    end

    assign Ovf = r_ovf;
`endif

    logic w_unused;
    assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1], r_vld[RCA_MAX_STAGES-1], w_c_msb};

endmodule

// File: tb/tb_pipelined_ripple_carry_adder.sv
// tb/tb_pipelined_ripple_carry_adder.sv - scoreboard bench for pipelined_ripple_carry_adder

module tb_pipelined_ripple_carry_adder;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout;
    logic [W-1:0] A, B, S;
`ifdef PIPELINED_RCA_OVF_EN
    logic         Ovf, o1, o8, o64;
`endif

    logic        sw_valid, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic        rd1, v1, c1, rd8, v8, c8, rd64, v64, c64;
    logic [7:0]  s1, s8;
    logic [63:0] s64;

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    exp_t q8[$];
    exp_t q64[$];

    pipelined_ripple_carry_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout)
`ifdef PIPELINED_RCA_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    pipelined_ripple_carry_adder #(.WIDTH(8), .STAGES(1)) u_w8s1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rd1),
        .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .Sub(sw_sub),
        .out_valid(v1), .out_ready(1'b1), .S(s1), .Cout(c1)
`ifdef PIPELINED_RCA_OVF_EN
        , .Ovf(o1)
`endif
    );

    pipelined_ripple_carry_adder #(.WIDTH(8), .STAGES(8)) u_w8s8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rd8),
        .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .Sub(sw_sub),
        .out_valid(v8), .out_ready(1'b1), .S(s8), .Cout(c8)
`ifdef PIPELINED_RCA_OVF_EN
        , .Ovf(o8)
`endif
    );

    pipelined_ripple_carry_adder #(.WIDTH(64), .STAGES(4)) u_w64s4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rd64),
        .A(sw_a), .B(sw_b), .Cin(sw_cin), .Sub(sw_sub),
        .out_valid(v64), .out_ready(1'b1), .S(s64), .Cout(c64)
`ifdef PIPELINED_RCA_OVF_EN
        , .Ovf(o64)
`endif
    );

    // {carry/no-borrow, w-bit result} from plain integer arithmetic
    function automatic logic [64:0] ref_sum(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
        logic [64:0] m, aa, bb, full;
        logic        co;
        m  = (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
        aa = {1'b0, a} & m;
        bb = {1'b0, b} & m;
        if (!sub) begin
            full = aa + bb + 65'(cin);
            co   = full[w];
        end else begin
            full = aa - bb - 65'(cin);
            co   = (aa >= (bb + 65'(cin)));
        end
        return {co, full[63:0] & m[63:0]};
    endfunction

    function automatic logic ref_ovf32(input logic [31:0] a, input logic [31:0] b,
                                       input logic cin, input logic sub);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
        return (r > SMAX) || (r < SMIN);
    endfunction

    task automatic drive_beat(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic ci, input logic su);
        in_valid = v; A = a; B = b; Cin = ci; Sub = su;
    endtask

    task automatic push_main();
        exp_t        e;
        logic [64:0] r;
        r     = ref_sum(W, {32'b0, A}, {32'b0, B}, Cin, Sub);
        e.s   = r[63:0];
        e.c   = r[64];
        e.v   = ref_ovf32(A, B, Cin, Sub);
        e.acc = ecount + 1;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        drive_beat(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (S !== '0) begin errors++; $display("FAIL reset_S: got %h want 0", S); end
        checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout: got %b want 0", Cout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef PIPELINED_RCA_OVF_EN
        checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_Ovf: got %b want 0", Ovf); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_carry_chain();
        int acc, lat;
        bit seen;
        out_ready = 1'b1;
        drive_beat(1, 32'hFFFF_FFFF, 32'h0, 1, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL carry_in_ready: got %b want 1", in_ready); end
        acc = ecount + 1;
        @(posedge clk); #1;
        drive_beat(0, 0, 0, 0, 0);
        seen = 0; lat = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
                lat  = ecount - acc + 1;
                checks++; if (lat != ST) begin errors++; $display("FAIL carry_latency: got %0d want %0d", lat, ST); end
                checks++; if (S !== 32'h0) begin errors++; $display("FAIL carry_S: got %h want 00000000", S); end
                checks++; if (Cout !== 1'b1) begin errors++; $display("FAIL carry_Cout: got %b want 1", Cout); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL carry_timeout: got no out_valid want one result"); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_one_cycle: got out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_subtract();
        exp_t e;
        int   got, last;
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        ta[0] = 32'd5; tb[0] = 32'd7;
        ta[1] = 32'd7; tb[1] = 32'd5;
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_beat(1, ta[i], tb[i], 0, 1);
            @(negedge clk);
            if (in_valid && in_ready) push_main();
            @(posedge clk); #1;
        end
        drive_beat(0, 0, 0, 0, 0);
        got = 0; last = -10;
        for (int i = 0; i < 20 && got < 2; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL sub_extra: got unexpected result %h want none", S);
                end else begin
                    e = q.pop_front();
                    if (S !== e.s[31:0] || Cout !== e.c) begin
                        errors++; $display("FAIL sub_result%0d: got %h/%b want %h/%b", got, S, Cout, e.s[31:0], e.c);
                    end
                end
                if (got == 1) begin
                    checks++; if (ecount != last + 1) begin errors++; $display("FAIL sub_consecutive: got gap %0d want 1", ecount - last); end
                end
                last = ecount;
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 2) begin errors++; $display("FAIL sub_timeout: got %0d results want 2", got); end
    endtask

    task automatic test_stream_backpressure();
        exp_t        e;
        int          sent, got, budget;
        logic [31:0] held_s;
        logic        held_c, prev_stall;
        q.delete();
        sent = 0; got = 0; budget = 0; prev_stall = 0; held_s = '0; held_c = 0;
        while (got < 10 && budget < 200) begin
            if (sent < 10) drive_beat(1, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            else           drive_beat(0, 0, 0, 0, 0);
            out_ready = !(budget >= 6 && budget < 9);
            @(negedge clk);
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || S !== held_s || Cout !== held_c) begin
                    errors++; $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b", out_valid, S, Cout, held_s, held_c);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_s = S; held_c = Cout;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got %h want none", S);
                end else begin
                    e = q.pop_front();
                    if (S !== e.s[31:0] || Cout !== e.c) begin
                        errors++; $display("FAIL stream_beat%0d: got %h/%b want %h/%b", got, S, Cout, e.s[31:0], e.c);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                push_main();
                sent++;
            end
            @(posedge clk); #1;
            budget++;
        end
        checks++; if (got != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", got); end
        out_ready = 1'b1;
        drive_beat(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midflight();
        int ghosts;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(1, $urandom, $urandom, 0, 0);
            @(posedge clk); #1;
        end
        drive_beat(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (S !== '0 || Cout !== 1'b0) begin errors++; $display("FAIL midrst_S: got %h/%b want 0/0", S, Cout); end
        ghosts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ghosts++;
        end
        checks++; if (ghosts != 0) begin errors++; $display("FAIL midrst_ghost: got %0d results want 0", ghosts); end
        @(posedge clk); #1;
    endtask

    task automatic test_param_sweep();
        exp_t        e;
        logic [64:0] r;
        int          sent, cyc;
        q1.delete(); q8.delete(); q64.delete();
        sent = 0;
        for (cyc = 0; cyc < 80 && (sent < 12 || q1.size() != 0 || q8.size() != 0 || q64.size() != 0); cyc++) begin
            if (sent == 0) begin
                sw_valid = 1; sw_a = '1; sw_b = '0; sw_cin = 1; sw_sub = 0;
            end else if (sent == 1) begin
                sw_valid = 1; sw_a = '0; sw_b = 64'd1; sw_cin = 0; sw_sub = 1;
            end else if (sent < 12) begin
                sw_valid = 1; sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
                sw_cin = 1'($urandom_range(1)); sw_sub = 1'($urandom_range(1));
            end else begin
                sw_valid = 0;
            end
            @(negedge clk);
            if (v1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin errors++; $display("FAIL w8s1_extra: got %h want none", s1); end
                else begin
                    e = q1.pop_front();
                    if (s1 !== e.s[7:0] || c1 !== e.c || (ecount - e.acc + 1) != 1) begin
                        errors++; $display("FAIL w8s1: got %h/%b lat %0d want %h/%b lat 1", s1, c1, ecount - e.acc + 1, e.s[7:0], e.c);
                    end
                end
            end
            if (v8 === 1'b1) begin
                checks++;
                if (q8.size() == 0) begin errors++; $display("FAIL w8s8_extra: got %h want none", s8); end
                else begin
                    e = q8.pop_front();
                    if (s8 !== e.s[7:0] || c8 !== e.c || (ecount - e.acc + 1) != 8) begin
                        errors++; $display("FAIL w8s8: got %h/%b lat %0d want %h/%b lat 8", s8, c8, ecount - e.acc + 1, e.s[7:0], e.c);
                    end
                end
            end
            if (v64 === 1'b1) begin
                checks++;
                if (q64.size() == 0) begin errors++; $display("FAIL w64s4_extra: got %h want none", s64); end
                else begin
                    e = q64.pop_front();
                    if (s64 !== e.s || c64 !== e.c || (ecount - e.acc + 1) != 4) begin
                        errors++; $display("FAIL w64s4: got %h/%b lat %0d want %h/%b lat 4", s64, c64, ecount - e.acc + 1, e.s, e.c);
                    end
                end
            end
            if (sw_valid && rd1 && rd8 && rd64) begin
                e.acc = ecount + 1; e.v = 0;
                r = ref_sum(8, sw_a, sw_b, sw_cin, sw_sub);  e.s = r[63:0]; e.c = r[64]; q1.push_back(e); q8.push_back(e);
                r = ref_sum(64, sw_a, sw_b, sw_cin, sw_sub); e.s = r[63:0]; e.c = r[64]; q64.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sent != 12 || q1.size() != 0 || q8.size() != 0 || q64.size() != 0) begin
            errors++; $display("FAIL sweep_drain: got sent=%0d pending=%0d/%0d/%0d want 12/0/0/0", sent, q1.size(), q8.size(), q64.size());
        end
        sw_valid = 0;
    endtask

`ifdef PIPELINED_RCA_OVF_EN
    task automatic test_ovf();
        exp_t        e;
        int          got;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic        ts [3];
        logic        tv [3];
        ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h1; ts[0] = 0; tv[0] = 1;
        ta[1] = 32'h8000_0000; tb[1] = 32'h1; ts[1] = 1; tv[1] = 1;
        ta[2] = 32'h1;         tb[2] = 32'h1; ts[2] = 0; tv[2] = 0;
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_beat(1, ta[i], tb[i], 0, ts[i]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_main();
                q[q.size()-1].v = tv[i];
            end
            @(posedge clk); #1;
        end
        drive_beat(0, 0, 0, 0, 0);
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL ovf_extra: got %h want none", S); end
                else begin
                    e = q.pop_front();
                    if (Ovf !== e.v || S !== e.s[31:0]) begin
                        errors++; $display("FAIL ovf_beat%0d: got ovf=%b S=%h want ovf=%b S=%h", got, Ovf, S, e.v, e.s[31:0]);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 3) begin errors++; $display("FAIL ovf_timeout: got %0d want 3", got); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 0; A = '0; B = '0; Cin = 0; Sub = 0; out_ready = 1'b1;
        sw_valid = 0; sw_a = '0; sw_b = '0; sw_cin = 0; sw_sub = 0;
        test_reset();
        test_carry_chain();
        test_subtract();
        test_stream_backpressure();
        test_reset_midflight();
        test_param_sweep();
`ifdef PIPELINED_RCA_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
